red_pitaya_iq_na_accumulator: RTL and testbench
===============================================

# red_pitaya_iq_na_accumulator

Parametrised network-analyzer accumulator: the next-generation, multi-channel replacement for the fixed two-quadrature sleep/average logic embedded in the IQ block. It sits after the quadrature low-pass filters. On each trigger (a frequency-step write) it waits a programmable number of settling cycles. It then sums a programmable number of samples on every channel and publishes a frozen result snapshot with a done pulse. Beyond the old logic, it adds abort, continuous re-arm, a snapshot register that remains readable while the next point accumulates, and optional saturation.

## Interface
- CHANNELS, 2, number of parallel input channels (I, Q, extra IQ blocks)
- INBITS, 24, signed sample width per channel
- SUMBITS, 62, signed accumulator and snapshot width per channel; must be at least INBITS+1
- CNTBITS, 32, width of the sleep and averages counters
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- dat_i  in  CHANNELS*INBITS  packed signed samples; channel k is bits [k*INBITS +: INBITS]
- trig_i  in  1  single-cycle start strobe
- abort_i  in  1  single-cycle abort strobe
- cont_i  in  1  continuous mode: re-arm automatically after done
- averages_i  in  CNTBITS  samples to sum; latched at trigger
- sleep_i  in  CNTBITS  settling cycles before summing; latched at trigger
- busy_o  out  1  high in SLEEP or AVERAGE
- done_o  out  1  one-cycle pulse when a new snapshot is published
- sum_o  out  CHANNELS*SUMBITS  packed snapshot of the last completed sums
- points_o  out  CNTBITS  count of snapshots published since the last reset (wraps)
- overflow_o  out  1  sticky flag: some channel saturated in the current point

## Operation
- States: IDLE, SLEEP, AVERAGE. Reset enters IDLE.
- IDLE + trig_i: latch averages_i and sleep_i, clear the working sums, then go to SLEEP.
  - If the latched sleep is 0, go straight to AVERAGE.
- SLEEP: decrement the sleep counter each cycle. Go to AVERAGE on the cycle the counter reaches 0.
- AVERAGE: add the sign-extended dat_i of each channel to its working sum and decrement the remaining count.
  - After the last addition: copy the working sums to sum_o, pulse done_o, increment points_o.
- After done, the next state depends on cont_i:
  - cont_i=1: clear the working sums, reload the latched counts, and go to SLEEP.
  - cont_i=0: go to IDLE.
- Latched averages=0: after sleep, publish all-zero sums with a done pulse. No sample is added.
- trig_i in SLEEP or AVERAGE: restart immediately. Relatch the counts, clear the working sums, go to SLEEP. No done pulse for the abandoned point.
- abort_i: go to IDLE. Working sums are discarded; sum_o and points_o are unchanged.
- trig_i and abort_i in the same cycle: trig_i wins.
- sum_o changes only on a done cycle; it holds its value otherwise, including after abort.
- overflow_o clears on trigger or re-arm and sets on any saturation event. Never set without the macro.

## Timing
- Reset values: busy_o=0, done_o=0, sum_o=0, points_o=0, overflow_o=0, state IDLE.
- Trigger at cycle t with sleep S and averages N:
  - busy_o is high from t+1.
  - Samples presented at cycles t+1+S through t+S+N are summed.
  - done_o and the new sum_o appear at t+S+N+1.
  - busy_o drops at t+S+N+1 when cont_i=0. With cont_i=1 it stays high.
- Reset mid-operation takes effect on the next edge. All outputs return to their reset values.
- Maximum sleep and averages: 2^CNTBITS-1. Counters never wrap inside a point.

## Configuration
- IQ_NA_SATURATE_EN defined: each addition clamps to the SUMBITS signed range and sets overflow_o.
- IQ_NA_SATURATE_EN undefined: two's-complement wrap; overflow_o is tied to 0.

## Structure
- Package iq_na_pkg holds the state encoding (IDLE=0, SLEEP=1, AVERAGE=2) and the sign-extend and saturation helper functions.
- Sub-module red_pitaya_iq_na_acc_lane, instantiated once per channel via generate, holds one working sum plus saturation logic.
- Top level holds the FSM, counters, snapshot register and points counter.

## Test plan
- Basic point: CHANNELS=2, dat_i={-5,+3} constant, sleep=4, averages=10, trigger at t=0 → done at t=15, sum_o={-50,+30}, points_o=1.
- Zero cases: sleep=0, averages=0 → done at t=1 with sums 0. A further trigger with sleep=0, averages=1, dat_i=7 → sum 7 at t+2.
- Restart and abort: trigger, re-trigger at t=5 → a single done, timed from t=5. Trigger then abort at t=3 → no done, prior sum_o held. Simultaneous trig_i and abort_i → point runs.
- Continuous mode: cont_i=1, sleep=2, averages=3 → done pulses every 5 cycles and busy_o stays high. cont_i=0 → returns to IDLE after the next done.
- Saturation: SUMBITS=INBITS+1, dat_i=max positive, averages=4 → with the macro, sum clamps to max and overflow_o=1. Without it, the sum wraps and overflow_o=0.
- Reset in AVERAGE → all outputs 0 next cycle; a subsequent trigger behaves as the basic point.

Source files
------------

// File: rtl/iq_na_pkg.sv
// Shared types and arithmetic helpers for the IQ network-analyzer accumulator.
// The helpers work on MAX_W-bit containers so that any width up to MAX_W-1 can be used.
package iq_na_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SLEEP   = 2'd1,
    ST_AVERAGE = 2'd2
  } state_t;

  localparam int unsigned MAX_W = 128;

  function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] val,
                                                   input int unsigned width);
    logic signed [MAX_W-1:0] tmp_s;
    tmp_s = $signed(val << (MAX_W - width));
    return $unsigned(tmp_s >>> (MAX_W - width));
  endfunction

  function automatic logic fits(input logic [MAX_W-1:0] val, input int unsigned width);
    return sign_extend(val, width) == val;
  endfunction

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic [MAX_W-1:0] saturate(input logic [MAX_W-1:0] val,
                                                input int unsigned width);
    logic [MAX_W-1:0] max_s;
    max_s = {MAX_W{1'b1}} >> (MAX_W - width + 1);
    if (fits(val, width)) begin
      return val;
    end else if (val[MAX_W-1]) begin
      return ~max_s;
    end else begin
      return max_s;
    end
  endfunction

endpackage

// File: rtl/red_pitaya_iq_na_acc_lane.sv
// One accumulator lane: a working sum plus the combinational next value of that sum.
// Optional clamping is enabled by defining IQ_NA_SATURATE_EN.
module red_pitaya_iq_na_acc_lane
  import iq_na_pkg::*;
#(
  parameter int INBITS  = 24,
  parameter int SUMBITS = 62
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear,
  input  logic               add,
  input  logic [INBITS-1:0]  dat_i,
  output logic [SUMBITS-1:0] sum_next,
  output logic               sat
);

  logic [SUMBITS-1:0] sum_r;
  logic [MAX_W-1:0]   sum_ext_s;
  logic [MAX_W-1:0]   dat_ext_s;
  logic [MAX_W-1:0]   full_s;

  assign sum_ext_s = sign_extend(MAX_W'(sum_r), SUMBITS);
  assign dat_ext_s = sign_extend(MAX_W'(dat_i), INBITS);
  assign full_s    = sum_ext_s + dat_ext_s;

`ifdef IQ_NA_SATURATE_EN
  logic [MAX_W-1:0] clamp_s;
  logic             unused_hi_s;
  assign clamp_s     = saturate(full_s, SUMBITS);
  assign sum_next    = clamp_s[SUMBITS-1:0];
  assign sat         = ~fits(full_s, SUMBITS);
  assign unused_hi_s = ^clamp_s[MAX_W-1:SUMBITS];
`else
  logic unused_hi_s;
  assign sum_next    = full_s[SUMBITS-1:0];
  assign sat         = 1'b0;
  assign unused_hi_s = ^full_s[MAX_W-1:SUMBITS];
`endif

  // Working sum: cleared between points, otherwise advanced on each accepted sample.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      sum_r <= {SUMBITS{1'b0}};
    end else if (add) begin
      sum_r <= sum_next;
    end else begin
      sum_r <= sum_r;
    end
  end

endmodule

// File: rtl/red_pitaya_iq_na_accumulator.sv
// Multi-channel network-analyzer accumulator: settle, sum N samples per channel, publish snapshot.
// Define IQ_NA_SATURATE_EN to clamp sums and report overflow; otherwise sums wrap.
module red_pitaya_iq_na_accumulator
  import iq_na_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int INBITS   = 24,
  parameter int SUMBITS  = 62,
  parameter int CNTBITS  = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [CHANNELS*INBITS-1:0]  dat_i,
  input  logic                        trig_i,
  input  logic                        abort_i,
  input  logic                        cont_i,
  input  logic [CNTBITS-1:0]          averages_i,
  input  logic [CNTBITS-1:0]          sleep_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [CHANNELS*SUMBITS-1:0] sum_o,
  output logic [CNTBITS-1:0]          points_o,
  output logic                        overflow_o
);

  localparam logic [CNTBITS-1:0] CNT_ZERO = {CNTBITS{1'b0}};
  localparam logic [CNTBITS-1:0] CNT_ONE  = CNTBITS'(1);

  state_t                      state_r;
  logic [CNTBITS-1:0]          sleep_lat_r;
  logic [CNTBITS-1:0]          avg_lat_r;
  logic [CNTBITS-1:0]          sleep_cnt_r;
  logic [CNTBITS-1:0]          avg_cnt_r;
  logic [CHANNELS*SUMBITS-1:0] next_sum_s;
  logic [CHANNELS-1:0]         sat_s;
  logic                        lane_add_s;
  logic                        lane_clear_s;
  logic                        pub_s;
  logic                        pub_sum_s;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_lane
      red_pitaya_iq_na_acc_lane #(
        .INBITS (INBITS),
        .SUMBITS(SUMBITS)
      ) u_lane (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (lane_clear_s),
        .add     (lane_add_s),
        .dat_i   (dat_i[k*INBITS +: INBITS]),
        .sum_next(next_sum_s[k*SUMBITS +: SUMBITS]),
        .sat     (sat_s[k])
      );
    end
  endgenerate

  // Decode this cycle's publish event and lane control; lanes hold only mid-point.
  always_comb begin
    pub_s        = 1'b0;
    pub_sum_s    = 1'b0;
    lane_add_s   = 1'b0;
    lane_clear_s = 1'b1;
    if (trig_i) begin
      pub_s = (sleep_i == CNT_ZERO) && (averages_i == CNT_ZERO);
    end else if (abort_i) begin
      pub_s = 1'b0;
    end else begin
      case (state_r)
        ST_SLEEP: begin
          pub_s = (sleep_cnt_r <= CNT_ONE) && (avg_lat_r == CNT_ZERO);
        end
        ST_AVERAGE: begin
          pub_s        = (avg_cnt_r <= CNT_ONE);
          pub_sum_s    = (avg_cnt_r == CNT_ONE);
          lane_add_s   = (avg_cnt_r != CNT_ZERO);
          lane_clear_s = (avg_cnt_r <= CNT_ONE);
        end
        default: begin
          pub_s = 1'b0;
        end
      endcase
    end
  end

`ifndef IQ_NA_SATURATE_EN
  logic unused_sat_s;
  assign unused_sat_s = ^sat_s;
`endif

  // FSM, counters, snapshot and points counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      sleep_lat_r <= CNT_ZERO;
      avg_lat_r   <= CNT_ZERO;
      sleep_cnt_r <= CNT_ZERO;
      avg_cnt_r   <= CNT_ZERO;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      sum_o       <= {(CHANNELS*SUMBITS){1'b0}};
      points_o    <= CNT_ZERO;
      overflow_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
`ifdef IQ_NA_SATURATE_EN
      if (lane_add_s && (|sat_s)) begin
        overflow_o <= 1'b1;
      end
`endif
      if (pub_s) begin
        sum_o    <= pub_sum_s ? next_sum_s : {(CHANNELS*SUMBITS){1'b0}};
        done_o   <= 1'b1;
        points_o <= points_o + CNT_ONE;
      end

      if (trig_i) begin
        sleep_lat_r <= sleep_i;
        avg_lat_r   <= averages_i;
        sleep_cnt_r <= sleep_i;
        avg_cnt_r   <= averages_i;
        overflow_o  <= 1'b0;
        if (sleep_i != CNT_ZERO) begin
          state_r <= ST_SLEEP;
          busy_o  <= 1'b1;
        end else if (averages_i != CNT_ZERO) begin
          state_r <= ST_AVERAGE;
          busy_o  <= 1'b1;
        end else begin
          // Empty point published at the trigger edge itself.
          state_r <= cont_i ? ST_AVERAGE : ST_IDLE;
          busy_o  <= cont_i;
        end
      end else if (abort_i) begin
        state_r <= ST_IDLE;
        busy_o  <= 1'b0;
      end else if (pub_s) begin
        sleep_cnt_r <= sleep_lat_r;
        avg_cnt_r   <= avg_lat_r;
        busy_o      <= cont_i;
        if (cont_i) begin
          overflow_o <= 1'b0;
          state_r    <= (sleep_lat_r != CNT_ZERO) ? ST_SLEEP : ST_AVERAGE;
        end else begin
          state_r <= ST_IDLE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy_o <= 1'b0;
          end
          ST_SLEEP: begin
            if (sleep_cnt_r > CNT_ONE) begin
              sleep_cnt_r <= sleep_cnt_r - CNT_ONE;
            end else begin
              state_r <= ST_AVERAGE;
            end
          end
          ST_AVERAGE: begin
            avg_cnt_r <= avg_cnt_r - CNT_ONE;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_iq_na_accumulator.sv
// Self-checking bench: constant-data vector table, hand-written corner sequences,
// and randomized points checked against a timing/sum model derived from the point rules.
module tb_red_pitaya_iq_na_accumulator;

  localparam int CH = 2;
  localparam int IB = 24;
  localparam int SB = 62;
  localparam int CB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, trig, abrt, cont;
  logic [CH*IB-1:0]   dat;
  logic [CB-1:0]      avg, slp;
  logic               busy, done, ovf;
  logic [CH*SB-1:0]   sum;
  logic [CB-1:0]      points;

  logic               trig2, abrt2, cont2;
  logic [IB-1:0]      dat2;
  logic [7:0]         avg2, slp2;
  logic               busy2, done2, ovf2;
  logic [IB:0]        sum2;
  logic [7:0]         points2;

  red_pitaya_iq_na_accumulator #(
    .CHANNELS(CH), .INBITS(IB), .SUMBITS(SB), .CNTBITS(CB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .dat_i(dat), .trig_i(trig), .abort_i(abrt),
    .cont_i(cont), .averages_i(avg), .sleep_i(slp), .busy_o(busy),
    .done_o(done), .sum_o(sum), .points_o(points), .overflow_o(ovf)
  );

  red_pitaya_iq_na_accumulator #(
    .CHANNELS(1), .INBITS(IB), .SUMBITS(IB+1), .CNTBITS(8)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .dat_i(dat2), .trig_i(trig2), .abort_i(abrt2),
    .cont_i(cont2), .averages_i(avg2), .sleep_i(slp2), .busy_o(busy2),
    .done_o(done2), .sum_o(sum2), .points_o(points2), .overflow_o(ovf2)
  );

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    int     s;
    int     n;
    longint d0;
    longint d1;
    int     lat;
    longint e0;
    longint e1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ch_sum(input int k);
    logic signed [SB-1:0] v;
    v = sum[k*SB +: SB];
    return v;
  endfunction

  task automatic set_dat(input longint d0, input longint d1);
    dat = {IB'(d1), IB'(d0)};
  endtask

  // Constant-data point with table-supplied expectations.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    logic [CB-1:0] p0;
    p0  = points;
    slp = CB'(v.s);
    avg = CB'(v.n);
    set_dat(v.d0, v.d1);
    trig = 1'b1;
    lat  = -1;
    for (int j = 1; j <= 200; j++) begin
      step();
      trig = 1'b0;
      if (done) begin
        lat = j;
        break;
      end
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " sum0"}, ch_sum(0), v.e0);
    check({tag, " sum1"}, ch_sum(1), v.e1);
    check({tag, " points"}, points, p0 + 1);
    check({tag, " busy_after"}, busy, 0);
  endtask

  // Random-data point: expected done cycle and sums come from the window rule
  // (samples in cycles S+1..S+N after the trigger, done at S+N+1).
  task automatic run_point(input int s, input int n, input string tag);
    longint e0, e1, d0, d1;
    logic signed [IB-1:0] r;
    logic [CB-1:0] p0;
    e0 = 0;
    e1 = 0;
    p0 = points;
    slp = CB'(s);
    avg = CB'(n);
    trig = 1'b1;
    for (int j = 1; j <= s + n + 1; j++) begin
      step();
      trig = 1'b0;
      check({tag, " done"}, done, (j == s + n + 1) ? 1 : 0);
      if (j == s + n + 1) begin
        check({tag, " sum0"}, ch_sum(0), e0);
        check({tag, " sum1"}, ch_sum(1), e1);
        check({tag, " points"}, points, p0 + 1);
      end else begin
        check({tag, " busy"}, busy, 1);
      end
      r = IB'($urandom);
      d0 = r;
      r = IB'($urandom);
      d1 = r;
      set_dat(d0, d1);
      if (j >= s + 1 && j <= s + n) begin
        e0 += d0;
        e1 += d1;
      end
    end
  endtask

  initial begin
    int lat, cnt;
    longint prev0, prev1;
    logic [CB-1:0] p0;
    logic signed [IB:0] s2;

    rst = 1'b1; trig = 1'b0; abrt = 1'b0; cont = 1'b0;
    dat = '0; avg = '0; slp = '0;
    trig2 = 1'b0; abrt2 = 1'b0; cont2 = 1'b0; dat2 = '0; avg2 = '0; slp2 = '0;
    step();
    step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum0", ch_sum(0), 0);
    check("reset sum1", ch_sum(1), 0);
    check("reset points", points, 0);
    check("reset overflow", ovf, 0);
    rst = 1'b0;
    step();

    vecs[0] = '{4, 10, -5, 3, 15, -50, 30};
    vecs[1] = '{0, 0, 9, 9, 1, 0, 0};
    vecs[2] = '{0, 1, 7, 7, 2, 7, 7};
    vecs[3] = '{3, 0, 1, 1, 4, 0, 0};
    vecs[4] = '{1, 5, -100, 200, 7, -500, 1000};
    vecs[5] = '{2, 3, 8388607, -8388608, 6, 25165821, -25165824};
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Restart: re-trigger at t=5 yields exactly one done timed from the restart.
    run_vec(vecs[0], "pre_restart");
    slp = 4; avg = 10; set_dat(-5, 3); trig = 1'b1;
    step(); trig = 1'b0;
    repeat (4) step();
    trig = 1'b1;
    cnt = 0; lat = -1;
    for (int j = 1; j <= 25; j++) begin
      step();
      trig = 1'b0;
      if (done) begin
        cnt++;
        lat = j;
      end
    end
    check("restart done count", cnt, 1);
    check("restart latency", lat, 15);
    check("restart sum0", ch_sum(0), -50);

    // Abort at t=3: no done, snapshot and points held.
    prev0 = ch_sum(0); prev1 = ch_sum(1); p0 = points;
    slp = 1; avg = 3; set_dat(100, 100); trig = 1'b1;
    step(); trig = 1'b0;
    step(); step();
    abrt = 1'b1;
    step(); abrt = 1'b0;
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      if (done) cnt++;
      step();
    end
    check("abort done count", cnt, 0);
    check("abort sum0 held", ch_sum(0), prev0);
    check("abort sum1 held", ch_sum(1), prev1);
    check("abort points held", points, p0);
    check("abort busy", busy, 0);

    // Simultaneous trigger and abort: trigger wins.
    slp = 0; avg = 2; set_dat(1, 2); trig = 1'b1; abrt = 1'b1;
    lat = -1;
    for (int j = 1; j <= 10; j++) begin
      step();
      trig = 1'b0; abrt = 1'b0;
      if (done && lat < 0) lat = j;
    end
    check("trig_abort latency", lat, 3);
    check("trig_abort sum1", ch_sum(1), 4);

    // Continuous mode: done every 5 cycles with busy held, then stop after cont drops.
    cont = 1'b1; slp = 2; avg = 3; set_dat(1, -1); p0 = points; trig = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      trig = 1'b0;
      check($sformatf("cont done j%0d", j), done, (j >= 6 && (j - 6) % 5 == 0) ? 1 : 0);
      check($sformatf("cont busy j%0d", j), busy, 1);
    end
    cont = 1'b0;
    step();
    check("cont final done", done, 1);
    check("cont final busy", busy, 0);
    check("cont final sum0", ch_sum(0), 3);
    check("cont final sum1", ch_sum(1), -3);
    check("cont points", points, p0 + 4);
    step();
    check("cont idle done", done, 0);

    // Saturation lane: SUMBITS = INBITS+1, four maximum positive samples.
    slp2 = 0; avg2 = 4; dat2 = 24'h7FFFFF; trig2 = 1'b1;
    lat = -1;
    for (int j = 1; j <= 10; j++) begin
      step();
      trig2 = 1'b0;
      if (done2 && lat < 0) begin
        lat = j;
        s2 = sum2;
`ifdef IQ_NA_SATURATE_EN
        check("sat sum", s2, 16777215);
        check("sat overflow", ovf2, 1);
`else
        check("wrap sum", s2, -4);
        check("wrap overflow", ovf2, 0);
`endif
      end
    end
    check("sat latency", lat, 5);

    // Randomized points against the window model.
    for (int i = 0; i < 20; i++) begin
      run_point(int'($urandom_range(0, 5)), int'($urandom_range(0, 8)), $sformatf("rnd%0d", i));
    end

    // Reset while averaging clears everything; the basic point then runs normally.
    slp = 1; avg = 10; set_dat(-5, 3); trig = 1'b1;
    step(); trig = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset sum0", ch_sum(0), 0);
    check("midreset sum1", ch_sum(1), 0);
    check("midreset points", points, 0);
    check("midreset overflow", ovf, 0);
    rst = 1'b0;
    run_vec(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
